// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 controller: owns the PC, fetches over req/ack, issues one control word per cycle.
// Optional build macro CU_ILLEGAL_TRAP_EN: unrecognised opcodes halt the core instead of acting as NOPs.
module legv8_control_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ack,
    input  logic [31:0]       instr,
    input  logic [3:0]        status,
    output logic [4:0]        SA,
    output logic [4:0]        SB,
    output logic [4:0]        DA,
    output logic [63:0]       k,
    output logic [4:0]        FS,
    output logic              C0,
    output logic              B_Sel,
    output logic              EN_ALU,
    output logic              EN_B,
    output logic              EN_ADDR_ALU,
    output logic              ram_cs,
    output logic              ram_write_en,
    output logic              ram_read_en,
    output logic              w_reg,
    output logic              instr_done,
    output logic              illegal_op
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMemRd, StHalt} state_e;
    typedef enum logic [3:0] {
        OpAdd, OpSub, OpAnd, OpOrr, OpAddi, OpSubi, OpLdur, OpStur, OpB, OpCbz, OpNone
    } op_e;

    localparam logic [4:0] FsAnd = 5'b00000;
    localparam logic [4:0] FsOrr = 5'b00100;
    localparam logic [4:0] FsAdd = 5'b01000;
    localparam logic [4:0] FsSub = 5'b01001;

    state_e              state_q, state_d;
    op_e                 op_q, op_dec;
    logic [31:0]         ir_q;
    logic [ADDR_W-1:0]   pc_q, pc_d, pc_plus4, b_off, cbz_off;
    logic [4:0]          rd, rn, rm;
    logic [63:0]         imm12, imm9;
    logic                unused_status;

    assign rd       = ir_q[4:0];
    assign rn       = ir_q[9:5];
    assign rm       = ir_q[20:16];
    assign imm12    = {52'd0, ir_q[21:10]};
    assign imm9     = {{55{ir_q[20]}}, ir_q[20:12]};
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign b_off    = {{(ADDR_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
    assign cbz_off  = {{(ADDR_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
    // Only the zero flag matters to this subset.
    assign unused_status = ^status[3:1];

    always_comb begin
        op_dec = OpNone;
        if      (ir_q[31:21] == 11'b10001011000) op_dec = OpAdd;
        else if (ir_q[31:21] == 11'b11001011000) op_dec = OpSub;
        else if (ir_q[31:21] == 11'b10001010000) op_dec = OpAnd;
        else if (ir_q[31:21] == 11'b10101010000) op_dec = OpOrr;
        else if (ir_q[31:22] == 10'b1001000100)  op_dec = OpAddi;
        else if (ir_q[31:22] == 10'b1101000100)  op_dec = OpSubi;
        else if (ir_q[31:21] == 11'b11111000010) op_dec = OpLdur;
        else if (ir_q[31:21] == 11'b11111000000) op_dec = OpStur;
        else if (ir_q[31:26] == 6'b000101)       op_dec = OpB;
        else if (ir_q[31:24] == 8'b10110100)     op_dec = OpCbz;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            op_q    <= OpNone;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == StFetch && instr_ack) ir_q <= instr;
            if (state_q == StDecode) op_q <= op_dec;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StFetch:  if (instr_ack) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_plus4;
                case (op_q)
                    OpLdur: begin
                        state_d = StMemRd;
                        pc_d    = pc_q;
                    end
                    OpB:   pc_d = pc_q + b_off;
                    OpCbz: if (status[0]) pc_d = pc_q + cbz_off;
`ifdef CU_ILLEGAL_TRAP_EN
                    OpNone: begin
                        state_d = StHalt;
                        pc_d    = pc_q;
                    end
`endif
                    default: ;
                endcase
            end
            StMemRd: begin
                state_d = StFetch;
                pc_d    = pc_plus4;
            end
            StHalt:  ;
            default: state_d = StFetch;
        endcase
    end

    // Outputs are forced low while reset is high so an aborted instruction never writes.
    always_comb begin
        instr_req    = 1'b0;
        instr_addr   = '0;
        SA           = '0;
        SB           = '0;
        DA           = '0;
        k            = '0;
        FS           = '0;
        C0           = 1'b0;
        B_Sel        = 1'b0;
        EN_ALU       = 1'b0;
        EN_B         = 1'b0;
        EN_ADDR_ALU  = 1'b0;
        ram_cs       = 1'b0;
        ram_write_en = 1'b0;
        ram_read_en  = 1'b0;
        w_reg        = 1'b0;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        if (!reset) begin
            instr_addr = pc_q;
            unique case (state_q)
                StFetch: instr_req = 1'b1;
                StExec: begin
                    case (op_q)
                        OpAdd, OpSub, OpAnd, OpOrr, OpAddi, OpSubi: begin
                            SA         = rn;
                            DA         = rd;
                            EN_ALU     = 1'b1;
                            w_reg      = 1'b1;
                            instr_done = 1'b1;
                            C0         = (op_q == OpSub) || (op_q == OpSubi);
                            if (op_q == OpAddi || op_q == OpSubi) begin
                                B_Sel = 1'b1;
                                k     = imm12;
                            end else begin
                                SB = rm;
                            end
                            if      (op_q == OpAnd) FS = FsAnd;
                            else if (op_q == OpOrr) FS = FsOrr;
                            else if (C0)            FS = FsSub;
                            else                    FS = FsAdd;
                        end
                        OpLdur: begin
                            SA          = rn;
                            k           = imm9;
                            B_Sel       = 1'b1;
                            FS          = FsAdd;
                            EN_ADDR_ALU = 1'b1;
                            ram_cs      = 1'b1;
                            ram_read_en = 1'b1;
                        end
                        OpStur: begin
                            SA           = rn;
                            SB           = rd;
                            k            = imm9;
                            B_Sel        = 1'b1;
                            FS           = FsAdd;
                            EN_ADDR_ALU  = 1'b1;
                            EN_B         = 1'b1;
                            ram_cs       = 1'b1;
                            ram_write_en = 1'b1;
                            instr_done   = 1'b1;
                        end
                        OpB: instr_done = 1'b1;
                        OpCbz: begin
                            SA         = rd;
                            FS         = FsAdd;
                            B_Sel      = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: begin
`ifndef CU_ILLEGAL_TRAP_EN
                            instr_done = 1'b1;
`endif
                        end
                    endcase
                end
                StMemRd: begin
                    SA          = rn;
                    DA          = rd;
                    k           = imm9;
                    B_Sel       = 1'b1;
                    FS          = FsAdd;
                    EN_ADDR_ALU = 1'b1;
                    ram_cs      = 1'b1;
                    ram_read_en = 1'b1;
                    w_reg       = 1'b1;
                    instr_done  = 1'b1;
                end
                StHalt: begin
                    instr_addr = '0;
`ifdef CU_ILLEGAL_TRAP_EN
                    illegal_op = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed bench for legv8_control_unit; honours CU_ILLEGAL_TRAP_EN the same way as the design.
module tb_legv8_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_ack;
    logic [31:0] instr;
    logic [3:0]  status;
    logic [4:0]  SA, SB, DA, FS;
    logic [63:0] k;
    logic        C0, B_Sel, EN_ALU, EN_B, EN_ADDR_ALU;
    logic        ram_cs, ram_write_en, ram_read_en, w_reg, instr_done, illegal_op;
    logic [63:0] ctl;
    logic        bus_ok;

    int n_checks = 0;
    int n_errors = 0;

    legv8_control_unit dut (
        .clock        (clock),
        .reset        (reset),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_ack    (instr_ack),
        .instr        (instr),
        .status       (status),
        .SA           (SA),
        .SB           (SB),
        .DA           (DA),
        .k            (k),
        .FS           (FS),
        .C0           (C0),
        .B_Sel        (B_Sel),
        .EN_ALU       (EN_ALU),
        .EN_B         (EN_B),
        .EN_ADDR_ALU  (EN_ADDR_ALU),
        .ram_cs       (ram_cs),
        .ram_write_en (ram_write_en),
        .ram_read_en  (ram_read_en),
        .w_reg        (w_reg),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op)
    );

    always #5 clock = ~clock;

    // Every output except k, packed into one word for all-zero checks.
    assign ctl = {instr_req, instr_addr, SA, SB, DA, FS, C0, B_Sel, EN_ALU, EN_B, EN_ADDR_ALU,
                  ram_cs, ram_write_en, ram_read_en, w_reg, instr_done, illegal_op};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called in FETCH; returns with the DUT sitting in EXEC.
    task automatic issue(input logic [31:0] word);
        check("fetch_req", 64'(instr_req), 64'd1);
        instr     = word;
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        instr     = 32'hFFFF_FFFF;
        check("decode_quiet", 64'({instr_req, EN_ALU, EN_B, ram_cs, w_reg, instr_done}), 64'd0);
        step();
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            bus_ok = ({EN_ALU, EN_B, ram_read_en} inside {3'b000, 3'b001, 3'b010, 3'b100});
            check("bus_excl", 64'(bus_ok), 64'd1);
        end
    end

    initial begin
        reset     = 1'b1;
        instr_ack = 1'b0;
        instr     = 32'd0;
        status    = 4'd0;
        step();
        check("rst_outputs", ctl, 64'd0);
        check("rst_k", k, 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("fetch_req0", 64'(instr_req), 64'd1);
        check("fetch_addr0", 64'(instr_addr), 64'd0);

        // Late ack: request held, illegal word on the bus must not be captured.
        instr = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req", 64'(instr_req), 64'd1);
            check("wait_addr", 64'(instr_addr), 64'd0);
        end

        issue(32'h910017E1);  // ADDI X1,X31,#5
        check("addi_sa", 64'(SA), 64'd31);
        check("addi_da", 64'(DA), 64'd1);
        check("addi_k", k, 64'd5);
        check("addi_bsel", 64'(B_Sel), 64'd1);
        check("addi_fs", 64'(FS), 64'h08);
        check("addi_en", 64'({EN_ALU, w_reg, instr_done, C0}), 64'b1110);
        check("addi_illegal", 64'(illegal_op), 64'd0);
        step();
        check("addi_pc", 64'(instr_addr), 64'h4);

        issue(32'hF8008022);  // STUR X2,[X1,#8]
        check("stur_sel", 64'({SA, SB}), 64'({5'd1, 5'd2}));
        check("stur_k", k, 64'd8);
        check("stur_ctl", 64'({B_Sel, FS, EN_ALU, EN_B, EN_ADDR_ALU, ram_cs, ram_write_en,
                               ram_read_en, w_reg, instr_done}), 64'b1_01000_01_1_1_1_0_0_1);
        step();
        check("stur_we_off", 64'(ram_write_en), 64'd0);
        check("stur_pc", 64'(instr_addr), 64'h8);

        issue(32'hF8408023);  // LDUR X3,[X1,#8]
        check("ldur_ex", 64'({EN_ADDR_ALU, ram_cs, ram_read_en, w_reg, instr_done, EN_B}),
              64'b111000);
        check("ldur_ex_k", k, 64'd8);
        step();
        check("ldur_mem", 64'({EN_ADDR_ALU, ram_cs, ram_read_en, w_reg, instr_done, EN_ALU}),
              64'b111110);
        check("ldur_mem_da", 64'(DA), 64'd3);
        check("ldur_mem_sa", 64'(SA), 64'd1);
        step();
        check("ldur_pc", 64'(instr_addr), 64'hC);

        issue(32'h8B0700C5);  // ADD X5,X6,X7
        check("add_sel", 64'({SA, SB, DA}), 64'({5'd6, 5'd7, 5'd5}));
        check("add_ctl", 64'({FS, B_Sel, C0, EN_ALU, w_reg}), 64'b01000_0_0_1_1);
        step();
        check("add_pc", 64'(instr_addr), 64'h10);

        status = 4'b0001;
        issue(32'hB4000064);  // CBZ X4,#3 taken
        check("cbz_ctl", 64'({SA, FS, B_Sel, EN_ALU, w_reg, instr_done}),
              64'({5'd4, 5'b01000, 1'b1, 1'b0, 1'b0, 1'b1}));
        check("cbz_k", k, 64'd0);
        step();
        status = 4'b0000;
        check("cbz_taken_pc", 64'(instr_addr), 64'h1C);

        issue(32'hB4000064);  // CBZ not taken
        step();
        check("cbz_fall_pc", 64'(instr_addr), 64'h20);

        issue(32'h17FFFFFF);  // B #-1
        check("b_ctl", 64'({EN_ALU, EN_B, ram_cs, w_reg, instr_done}), 64'b00001);
        step();
        check("b_pc", 64'(instr_addr), 64'h1C);

        issue(32'hCB030041);  // SUB X1,X2,X3
        check("sub_ctl", 64'({FS, C0, B_Sel, SA, SB, DA}),
              64'({5'b01001, 1'b1, 1'b0, 5'd2, 5'd3, 5'd1}));
        step();
        issue(32'hD1000421);  // SUBI X1,X1,#1
        check("subi_ctl", 64'({FS, C0, B_Sel}), 64'b01001_1_1);
        check("subi_k", k, 64'd1);
        step();
        issue(32'h8A030041);  // AND
        check("and_fs", 64'({FS, C0}), 64'b00000_0);
        step();
        issue(32'hAA030041);  // ORR
        check("orr_fs", 64'({FS, C0}), 64'b00100_0);
        step();
        check("orr_pc", 64'(instr_addr), 64'h2C);

        issue(32'hFFFFFFFF);
`ifdef CU_ILLEGAL_TRAP_EN
        check("ill_exec_quiet", ctl & ~64'hFFFF_FFFF_8000_0000 | 64'(instr_req), 64'd0);
        check("ill_exec_done", 64'(instr_done), 64'd0);
        step();
        check("ill_halt", 64'({illegal_op, instr_req, instr_done}), 64'b100);
        step();
        check("ill_sticky", 64'({illegal_op, instr_req, instr_done}), 64'b100);
`else
        check("nop_done", 64'({instr_done, illegal_op, w_reg, EN_ALU}), 64'b1000);
        step();
        check("nop_pc", 64'(instr_addr), 64'h30);
`endif
        reset = 1'b1;
        #1;
        check("rst2_outputs", ctl, 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("rst2_fetch", 64'({instr_req, illegal_op}), 64'b10);
        check("rst2_pc", 64'(instr_addr), 64'h0);

        // Reset during EXEC of ADD aborts the write.
        issue(32'h8B0700C5);
        check("abort_pre_wreg", 64'(w_reg), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_wreg", 64'({w_reg, ram_write_en, instr_done}), 64'd0);
        step();
        check("abort_after", 64'({w_reg, ram_write_en}), 64'd0);
        reset = 1'b0;
        #1;
        check("abort_pc", 64'(instr_addr), 64'h0);
        step();
        check("abort_pc_hold", 64'({instr_req, instr_addr}), 64'({1'b1, 32'h0}));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
